// File: rtl/gate_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gate_sched_pkg
//  Brief    : Shared types for the gate scheduler: opcode and FSM state
//             encodings, accept-counter width and the round-robin helper.
//  Revision : 1.0 - initial release
// ============================================================================
package gate_sched_pkg;

    // Opcode encoding as seen on reqN_op.
    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    // Output-register occupancy.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Accept counter width is fixed, independent of the datapath width.
    localparam int CNT_W = 16;

    // After granting index g, the other requester gets priority next time.
    function automatic logic rr_after_grant(input logic granted_id);
        return ~granted_id;
    endfunction

endpackage : gate_sched_pkg
`default_nettype wire

// File: rtl/gate_unit.sv
`default_nettype none
// ============================================================================
//  Module   : gate_unit
//  Brief    : Purely combinational bitwise gate shared by both requesters.
//             op 00 AND, 01 OR, 10 XOR, 11 PASS-A.
//  Config   : GATE_SCHED_XOR_EN - when defined op 10 computes a ^ b;
//             otherwise op 10 yields y = 0 with err = 1.
//  Revision : 1.0 - initial release
// ============================================================================
module gate_unit
    import gate_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    // Decode the opcode and evaluate the selected bitwise function.
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR: begin
`ifdef GATE_SCHED_XOR_EN
                y   = a ^ b;
                err = 1'b0;
`else
                y   = '0;
                err = 1'b1;
`endif
            end
            OP_PASS: y = a;
        endcase
    end

endmodule : gate_unit
`default_nettype wire

// File: rtl/gate_sched.sv
`default_nettype none
// ============================================================================
//  Module   : gate_sched
//  Brief    : Two-requester round-robin scheduler in front of one shared
//             combinational gate unit, with a single-entry output register
//             (latency 1, back-to-back capable under rsp_ready).
//  Config   : GATE_SCHED_XOR_EN (consumed by gate_unit) enables XOR.
//  Revision : 1.0 - initial release
// ============================================================================
module gate_sched
    import gate_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    // Registered state
    state_e             state_q,    state_d;
    logic               rr_ptr_q,   rr_ptr_d;
    logic               rsp_id_q,   rsp_id_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q,  rsp_err_d;
    logic [CNT_W-1:0]   acc_cnt_q,  acc_cnt_d;

    // Arbitration and shared-unit signals
    logic               can_accept;
    logic               accept;
    logic               grant_id;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   unit_y;
    logic               unit_err;

    // The single gate instance; its operands come from the granted requester.
    gate_unit #(
        .WIDTH (WIDTH)
    ) u_gate_unit (
        .op  (sel_op),
        .a   (sel_a),
        .b   (sel_b),
        .y   (unit_y),
        .err (unit_err)
    );

    // Arbitration, operand mux, next-state and register-load decisions.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        acc_cnt_d  = acc_cnt_q;

        // Reset is folded in here so no handshake completes in a reset cycle.
        can_accept = !rst && ((state_q == ST_EMPTY) || rsp_ready);

        // Requester 1 wins when it is alone, or when both ask and it is its turn.
        grant_id   = req1_valid && (!req0_valid || rr_ptr_q);
        accept     = can_accept && (req0_valid || req1_valid);

        req0_ready = accept && !grant_id;
        req1_ready = accept &&  grant_id;

        sel_op     = grant_id ? req1_op : req0_op;
        sel_a      = grant_id ? req1_a  : req0_a;
        sel_b      = grant_id ? req1_b  : req0_b;

        if (accept) begin
            state_d    = ST_FULL;
            rr_ptr_d   = rr_after_grant(grant_id);
            rsp_id_d   = grant_id;
            rsp_data_d = unit_y;
            rsp_err_d  = unit_err;
            acc_cnt_d  = acc_cnt_q + 1'b1;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d    = ST_EMPTY;
        end
    end

    // State register; reset discards any held response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rr_ptr_q   <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            acc_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            acc_cnt_q  <= acc_cnt_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // Every accept advances the counter by exactly one (mod 2^16).
    a_cnt_step : assert property (@(posedge clk) disable iff (rst)
        accept |=> (acc_cnt_q == $past(acc_cnt_q) + 1'b1));

    // A stalled response must not change under the consumer.
    a_rsp_stable : assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> ($stable(rsp_data) && $stable(rsp_id) && $stable(rsp_err)));

    // At most one requester is granted per cycle.
    a_one_grant : assert property (@(posedge clk) !(req0_ready && req1_ready));

endmodule : gate_sched
`default_nettype wire

// File: tb/tb_gate_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_sched
//  Brief    : Self-checking bench for gate_sched (WIDTH = 8). Directed
//             scenarios plus random traffic against a behavioural model of
//             the scheduling rules, then a 65537-accept counter-wrap run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [W-1:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (plain integers, derived from the rules)
    bit       m_full;
    int       m_turn;      // which requester wins a tie next
    int       m_id;
    int       m_data;
    int       m_err;
    int       m_cnt;

    gate_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected gate result: {err, data}.
    function automatic int gate_ref(input int op, input int a, input int b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: begin
`ifdef GATE_SCHED_XOR_EN
                return a ^ b;
`else
                return 32'h100;   // err set, data zero
`endif
            end
            default: return a;
        endcase
    endfunction

    // One clock cycle: drive inputs, check readies, clock, update model, check outputs.
    task automatic cycle(input bit r, input bit v0, input bit v1,
                         input int op0, input int a0, input int b0,
                         input int op1, input int a1, input int b1,
                         input bit rr);
        bit can, acc;
        int g, res;
        rst = r; req0_valid = v0; req1_valid = v1; rsp_ready = rr;
        req0_op = op0[1:0]; req0_a = a0[W-1:0]; req0_b = b0[W-1:0];
        req1_op = op1[1:0]; req1_a = a1[W-1:0]; req1_b = b1[W-1:0];
        #1;
        can = !r && (!m_full || rr);
        acc = can && (v0 || v1);
        g   = (v0 && v1) ? m_turn : (v1 ? 1 : 0);
        check("req0_ready", {31'd0, req0_ready}, {31'd0, acc && g == 0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, acc && g == 1});
        @(posedge clk);
        #1;
        if (r) begin
            m_full = 0; m_turn = 0; m_id = 0; m_data = 0; m_err = 0; m_cnt = 0;
        end else if (acc) begin
            res    = (g == 0) ? gate_ref(op0, a0 & 8'hFF, b0 & 8'hFF)
                              : gate_ref(op1, a1 & 8'hFF, b1 & 8'hFF);
            m_full = 1;
            m_id   = g;
            m_data = res & 8'hFF;
            m_err  = (res >> 8) & 1;
            m_turn = 1 - g;
            m_cnt  = (m_cnt + 1) % 65536;
        end else if (m_full && rr) begin
            m_full = 0;
        end
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
        if (m_full || r) begin
            check("rsp_id",   {31'd0, rsp_id},   m_id);
            check("rsp_data", {24'd0, rsp_data}, m_data);
            check("rsp_err",  {31'd0, rsp_err},  m_err);
        end
    endtask

    task automatic idle(input bit rr);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    task automatic do_reset();
        cycle(1, 1, 1, 0, 1, 1, 0, 1, 1, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_full = 0; m_turn = 0; m_id = 0; m_data = 0; m_err = 0; m_cnt = 0;
        rst = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        @(posedge clk); #1;

        // Reset state
        do_reset();
        check("rst_valid", {31'd0, rsp_valid}, 0);
        check("rst_data",  {24'd0, rsp_data},  0);
        check("rst_rrptr", {31'd0, dut.rr_ptr_q}, 0);
        check("rst_cnt",   {16'd0, dut.acc_cnt_q}, 0);

        // Single AND request: 0xF0 & 0x3C = 0x30 from requester 0
        cycle(0, 1, 0, 0, 'hF0, 'h3C, 0, 0, 0, 1);
        check("and_valid", {31'd0, rsp_valid}, 1);
        check("and_id",    {31'd0, rsp_id},    0);
        check("and_data",  {24'd0, rsp_data},  'h30);
        idle(1);

        // Both valid every cycle: grants alternate 0,1,0,1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, 3, 16 + i, 0, 3, 32 + i, 0, 1);
            check("alt_valid", {31'd0, rsp_valid}, 1);
            check("alt_id",    {31'd0, rsp_id},    i % 2);
            check("alt_data",  {24'd0, rsp_data},  (i % 2 == 0) ? 16 + i : 32 + i);
        end
        idle(1);

        // Back-pressure: stall 3 cycles, then release accepts same cycle
        do_reset();
        cycle(0, 1, 1, 1, 'h0F, 'h30, 0, 'hFF, 'h81, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 2, 'h11, 'h22, 0, 'hFF, 'h81, 0);
            check("stall_data", {24'd0, rsp_data}, 'h3F);
            check("stall_id",   {31'd0, rsp_id},   0);
        end
        cycle(0, 1, 1, 2, 'h11, 'h22, 0, 'hFF, 'h81, 1);
        check("release_id",   {31'd0, rsp_id},   1);
        check("release_data", {24'd0, rsp_data}, 'h81);
        idle(1);

        // XOR from requester 1
        cycle(0, 0, 1, 0, 0, 0, 2, 'hAA, 'hFF, 1);
        check("xor_id", {31'd0, rsp_id}, 1);
`ifdef GATE_SCHED_XOR_EN
        check("xor_data", {24'd0, rsp_data}, 'h55);
        check("xor_err",  {31'd0, rsp_err},  0);
`else
        check("xor_data", {24'd0, rsp_data}, 'h00);
        check("xor_err",  {31'd0, rsp_err},  1);
`endif

        // Reset while a response is held, then a tie grants requester 0
        cycle(0, 1, 0, 3, 'h5A, 0, 0, 0, 0, 0);
        check("pre_rst_valid", {31'd0, rsp_valid}, 1);
        cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_valid", {31'd0, rsp_valid},   0);
        check("post_rst_rrptr", {31'd0, dut.rr_ptr_q}, 0);
        cycle(0, 1, 1, 3, 'h01, 0, 3, 'h02, 0, 1);
        check("post_rst_id", {31'd0, rsp_id}, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 3) != 0);
            check("rnd_rrptr", {31'd0, dut.rr_ptr_q}, m_turn);
            check("rnd_cnt",   {16'd0, dut.acc_cnt_q}, m_cnt);
        end

        // Counter wrap: 65537 accepts after reset leaves the counter at 1
        do_reset();
        for (int i = 0; i < 65537; i++)
            cycle(0, 1, 0, 1, i & 255, 0, 0, 0, 0, 1);
        check("cnt_wrap", {16'd0, dut.acc_cnt_q}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gate_sched
`default_nettype wire

// File: doc/gate_sched.md
GATE_SCHED -- requirements
Module: gate_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 1..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester N's operation accepted this cycle.
REQ-006 SHALL have ports req0_op / req1_op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 PASS-A.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-008 SHALL have port rsp_valid  output  1  response held in output register.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes response this cycle.
REQ-010 SHALL have port rsp_id  output  1  index of requester that issued the response.
REQ-011 SHALL have port rsp_data  output  WIDTH  gate result.
REQ-012 SHALL have port rsp_err  output  1  opcode rejected (see Configuration).

Function
REQ-013 SHALL share one combinational gate unit between two requesters; at most one accept per cycle.
REQ-014 SHALL have a two-state FSM: EMPTY (no response held) and FULL (response held); rsp_valid = (state == FULL).
REQ-015 SHALL accept when can_accept = EMPTY or (FULL and rsp_ready); no accept otherwise.
REQ-016 SHALL grant the requester selected by round-robin: only one valid -> it; both valid -> the one whose index equals rr_ptr.
REQ-017 SHALL drive reqN_ready = can_accept and grant to N; ready SHALL be 0 for a non-valid requester.
REQ-018 SHALL toggle rr_ptr to the non-granted index on every accept; rr_ptr SHALL hold when there is no accept.
REQ-019 SHALL register result, id and err on accept; response visible the cycle after accept (latency 1).
REQ-020 Transitions: EMPTY+accept -> FULL; FULL+rsp_ready+accept -> FULL (new data, back-to-back); FULL+rsp_ready+no accept -> EMPTY; FULL+!rsp_ready -> FULL with outputs stable.
REQ-021 SHALL keep rsp_data/rsp_id/rsp_err unchanged while rsp_valid and !rsp_ready.
REQ-022 Results are bitwise over WIDTH bits; PASS-A returns req_a unmodified; no carries or width extension.
REQ-023 SHALL keep a WIDTH-independent 16-bit accept counter, wrapping 0xFFFF -> 0x0000 (internal, for assertions).

Reset
REQ-024 On rst: state EMPTY, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, rr_ptr 0, counter 0.
REQ-025 Reset SHALL dominate every other event; a response held when rst is asserted SHALL be discarded, and no request is accepted in a reset cycle (req0_ready = req1_ready = 0).

Configuration
REQ-026 Macro GATE_SCHED_XOR_EN SHALL control XOR support.
REQ-027 With GATE_SCHED_XOR_EN defined: op 10 returns a ^ b with rsp_err 0.
REQ-028 Without GATE_SCHED_XOR_EN: op 10 is still accepted and arbitrated normally, but returns rsp_data 0 and rsp_err 1.

Structure
REQ-029 SHALL use package gate_sched_pkg holding the opcode enum (OP_AND, OP_OR, OP_XOR, OP_PASS) and the state enum (ST_EMPTY, ST_FULL).
REQ-030 The shared unit SHALL be sub-module gate_unit: purely combinational, inputs op/a/b, outputs y/err, and the only place containing the macro.

Verification
REQ-031 WIDTH=8, reset, then req0 valid op AND a=0xF0 b=0x3C, rsp_ready=1 -> next cycle rsp_valid 1, rsp_id 0, rsp_data 0x30.
REQ-032 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; four responses in four consecutive cycles.
REQ-033 Hold rsp_ready=0 for 3 cycles after the first accept -> both readies 0, response stable; rsp_ready=1 -> next accept in that same cycle.
REQ-034 req1 op XOR a=0xAA b=0xFF -> with macro: data 0x55, err 0; without macro: data 0x00, err 1.
REQ-035 Assert rst while rsp_valid=1 -> next cycle rsp_valid 0, rr_ptr 0; a subsequent simultaneous request grants req0.
REQ-036 Run 65537 accepts -> accept counter reads 0x0001, confirming wrap.
